// File: rtl/quad_encoder_emulator_if.sv
// Move-command channel of the quadrature encoder emulator: a signed step
// count, an edge period, a valid/ready handshake and an abort request.
interface quad_encoder_emulator_if #(
  parameter int REG_MAX = 64,
  parameter int DIV_W   = 16
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [REG_MAX-1:0] cmd_steps;
  logic [DIV_W-1:0]   cmd_period;
  logic               abort;

  modport master (output cmd_valid, cmd_steps, cmd_period, abort, input cmd_ready);
  modport slave  (input cmd_valid, cmd_steps, cmd_period, abort, output cmd_ready);
endinterface

// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: emits |cmd_steps| A/B edges spaced cmd_period
// clocks apart, tracks emitted position and drives a once-per-rev index.
module quad_encoder_emulator #(
  parameter int REG_MAX = 64,
  parameter int DIV_W   = 16,
  parameter int CPR     = 4000
) (
  input  logic                      clk,
  input  logic                      rst,
  quad_encoder_emulator_if.slave    cmd,
  output logic                      phaseA,
  output logic                      phaseB,
  output logic                      index,
  output logic                      busy,
  output logic                      done,
  output logic signed [REG_MAX-1:0] position
);
  localparam int                 REV_W      = $clog2(CPR);
  localparam logic [REV_W-1:0]   REV_LAST   = REV_W'(CPR - 1);
  localparam logic [REV_W-1:0]   REV_ONE    = REV_W'(1);
  localparam logic [DIV_W-1:0]   PERIOD_MIN = DIV_W'(2);
  localparam logic [DIV_W-1:0]   TIMER_ONE  = DIV_W'(1);
  localparam logic [REG_MAX-1:0] STEP_ONE   = REG_MAX'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_next;
  logic [REG_MAX-1:0] remaining;
  logic               dir;
  logic [DIV_W-1:0]   period;
  logic [DIV_W-1:0]   timer;
  logic [1:0]         q;
  logic [REV_W-1:0]   rev;

  logic               accept, cmd_zero;
  logic               edge_fire, last_edge, move_end;
  logic [1:0]         q_next;
  logic [REV_W-1:0]   rev_next;

  assign cmd.cmd_ready = (state == IDLE) && !cmd.abort;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign cmd_zero      = (cmd.cmd_steps == '0);
  assign busy          = (state == RUN);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_next = state;
    edge_fire  = 1'b0;
    last_edge  = 1'b0;
    move_end   = 1'b0;
    case (state)
      IDLE: if (accept && !cmd_zero) state_next = RUN;
      RUN: begin
        // Abort wins over an expiring timer: no edge on the aborting cycle.
        edge_fire = !cmd.abort && (timer == period - TIMER_ONE);
        last_edge = edge_fire && (remaining == STEP_ONE);
        move_end  = cmd.abort || last_edge;
        if (move_end) state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    q_next   = dir ? q - 2'd1 : q + 2'd1;
    rev_next = rev;
    if (dir) rev_next = (rev == '0) ? REV_LAST : rev - REV_ONE;
    else     rev_next = (rev == REV_LAST) ? '0 : rev + REV_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state is updated with non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: everything is reset here; there is no storage array to leave unreset.
      remaining <= '0;
      dir       <= 1'b0;
      period    <= PERIOD_MIN;
      timer     <= '0;
      q         <= 2'd0;
      rev       <= '0;
      phaseA    <= 1'b0;
      phaseB    <= 1'b0;
      index     <= 1'b1;
      position  <= '0;
      done      <= 1'b0;
    end else begin
      done <= (accept && cmd_zero) || move_end;
      if (accept) begin
        // Two's-complement negate keeps the most-negative count exact as unsigned.
        remaining <= cmd.cmd_steps[REG_MAX-1] ? (~cmd.cmd_steps + STEP_ONE) : cmd.cmd_steps;
        dir       <= cmd.cmd_steps[REG_MAX-1];
        period    <= (cmd.cmd_period < PERIOD_MIN) ? PERIOD_MIN : cmd.cmd_period;
        timer     <= '0;
      end else if (state == RUN) begin
        timer <= edge_fire ? '0 : timer + TIMER_ONE;
        if (edge_fire) begin
          // q0..q3 -> {A,B} = 00,10,11,01 (Gray sequence, A leads B going forward)
          q         <= q_next;
          phaseA    <= q_next[1] ^ q_next[0];
          phaseB    <= q_next[1];
          position  <= dir ? position - STEP_ONE : position + STEP_ONE;
          rev       <= rev_next;
          index     <= (rev_next == '0);
          remaining <= remaining - STEP_ONE;
        end
      end
    end
  end
endmodule
